// File: rtl/stack_unit.sv
// Purpose : hardware LIFO beside the ALU; registered top-of-stack for POP/RTN, push of ALU result.
// Latency : push/pop take effect at the sampling edge; stackout/count/flags valid 1 cycle later.
// Backpressure: none; rejected pushes (full) / pops (empty) set sticky overflow/underflow flags.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   push, pop, din    single-cycle strobes; push+pop replaces the top entry
//   clr_err           clears sticky error flags (a same-cycle error takes priority)
//   stackout          registered top-of-stack, 0 when empty
//   count/empty/full  occupancy decoded from the registered stack pointer
//   overflow/underflow sticky error flags
module stack_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_err,
    output logic [WIDTH-1:0] stackout,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW:0] LP_DEPTH = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LP_TWO   = (AW + 1)'(2);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_sp;
    logic [WIDTH-1:0] r_stackout;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_idx;
    logic [AW:0]      w_sp_nxt;
    logic [WIDTH-1:0] w_stackout_nxt;
    logic             w_ovf_set;
    logic             w_unf_set;
    logic [AW:0]      w_sp_m1;
    logic [AW:0]      w_sp_m2;

    assign w_empty = (r_sp == '0);
    assign w_full  = (r_sp == LP_DEPTH);
    // Only consumed when sp >= 1 (resp. >= 2), so these never wrap in use.
    assign w_sp_m1 = r_sp - 1'b1;
    assign w_sp_m2 = r_sp - LP_TWO;

    always_comb begin
        w_wr_en        = 1'b0;
        w_wr_idx       = r_sp[AW-1:0];
        w_sp_nxt       = r_sp;
        w_stackout_nxt = r_stackout;
        w_ovf_set      = 1'b0;
        w_unf_set      = 1'b0;

        unique case ({push, pop})
            2'b10: begin
                if (!w_full) begin
                    w_wr_en        = 1'b1;
                    w_wr_idx       = r_sp[AW-1:0];
                    w_sp_nxt       = r_sp + 1'b1;
                    w_stackout_nxt = din;
                end else begin
                    w_ovf_set = 1'b1;
                end
            end
            2'b01: begin
                if (!w_empty) begin
                    w_sp_nxt = w_sp_m1;
                    // Next top is the entry below the current one, read from the array
                    // into the stackout register so the ALU never sees a mem read path.
                    if (r_sp >= LP_TWO) begin
                        w_stackout_nxt = r_mem[w_sp_m2[AW-1:0]];
                    end else begin
                        w_stackout_nxt = '0;
                    end
                end else begin
                    w_unf_set = 1'b1;
                end
            end
            2'b11: begin
                if (!w_empty) begin
                    // Replace top in place; legal even when full since sp does not move.
                    w_wr_en        = 1'b1;
                    w_wr_idx       = w_sp_m1[AW-1:0];
                    w_stackout_nxt = din;
                end else begin
                    // Nothing to pop: still accept the push, but flag the missing pop.
                    w_wr_en        = 1'b1;
                    w_wr_idx       = '0;
                    w_sp_nxt       = (AW + 1)'(1);
                    w_stackout_nxt = din;
                    w_unf_set      = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Storage array is intentionally not reset; contents above sp are don't-care.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sp        <= '0;
            r_stackout  <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_sp        <= w_sp_nxt;
            r_stackout  <= w_stackout_nxt;
            // A new error event beats a coincident clear.
            r_overflow  <= w_ovf_set | (r_overflow  & ~clr_err);
            r_underflow <= w_unf_set | (r_underflow & ~clr_err);
        end
    end

    assign stackout  = r_stackout;
    assign count     = r_sp;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_stack_unit.sv
module tb_stack_unit;

    logic        clk;
    logic        reset;
    logic        push;
    logic        pop;
    logic [15:0] din;
    logic        clr_err;
    logic [15:0] stackout;
    logic [4:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;

    int total = 0;
    int bad   = 0;

    stack_unit #(.WIDTH(16), .DEPTH(16), .AW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .din       (din),
        .clr_err   (clr_err),
        .stackout  (stackout),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of strobes, then return 1 time unit after the edge with strobes idle.
    task automatic op(input logic p, input logic q, input logic [15:0] d, input logic c);
        push = p; pop = q; din = d; clr_err = c;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; din = 16'h0000; clr_err = 1'b0;
    endtask

    // Reset pulse placed between clock edges.
    task automatic pulse_reset();
        #2 reset = 1'b1;
        #2 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; push = 0; pop = 0; din = 0; clr_err = 0;
        #12;
        total++; if (stackout !== 16'h0000) begin bad++; $display("FAIL reset_stackout got=%h exp=0000", stackout); end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL reset_empty_full got=%b%b exp=10", empty, full); end
        total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", overflow, underflow); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_push_pop();
        logic [15:0] exp_v [3];
        exp_v[0] = 16'h0007; exp_v[1] = 16'hABCD; exp_v[2] = 16'h1234;
        op(1, 0, 16'h1234, 0);
        op(1, 0, 16'hABCD, 0);
        op(1, 0, 16'h0007, 0);
        total++; if (stackout !== 16'h0007) begin bad++; $display("FAIL pp_top got=%h exp=0007", stackout); end
        total++; if (count !== 5'd3) begin bad++; $display("FAIL pp_count got=%0d exp=3", count); end
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL pp_not_empty got=%b exp=0", empty); end
        for (int i = 0; i < 3; i++) begin
            total++; if (stackout !== exp_v[i]) begin bad++; $display("FAIL pp_pop%0d got=%h exp=%h", i, stackout, exp_v[i]); end
            op(0, 1, 16'h0000, 0);
        end
        total++; if (stackout !== 16'h0000 || empty !== 1'b1 || count !== 5'd0) begin
            bad++; $display("FAIL pp_final got=%h/%b/%0d exp=0000/1/0", stackout, empty, count);
        end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL pp_no_underflow got=%b exp=0", underflow); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 16; i++) op(1, 0, 16'(i), 0);
        total++; if (full !== 1'b1 || count !== 5'd16) begin bad++; $display("FAIL fill_full got=%b/%0d exp=1/16", full, count); end
        total++; if (stackout !== 16'd15) begin bad++; $display("FAIL fill_top got=%h exp=000f", stackout); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_no_ovf got=%b exp=0", overflow); end
        op(1, 0, 16'hFFFF, 0);
        total++; if (stackout !== 16'd15 || count !== 5'd16) begin bad++; $display("FAIL ovf_hold got=%h/%0d exp=000f/16", stackout, count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        op(0, 0, 16'h0000, 0);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        op(0, 0, 16'h0000, 1);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
        // Drain the full stack; each pop must present the entries 15..0 in order.
        for (int i = 15; i >= 0; i--) begin
            total++; if (stackout !== 16'(i)) begin bad++; $display("FAIL drain%0d got=%h exp=%h", i, stackout, 16'(i)); end
            op(0, 1, 16'h0000, 0);
        end
        total++; if (empty !== 1'b1 || stackout !== 16'h0000) begin bad++; $display("FAIL drain_end got=%b/%h exp=1/0000", empty, stackout); end
    endtask

    task automatic test_underflow();
        pulse_reset();
        op(0, 1, 16'h0000, 0);
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL unf_set got=%b exp=1", underflow); end
        total++; if (stackout !== 16'h0000 || count !== 5'd0) begin bad++; $display("FAIL unf_state got=%h/%0d exp=0000/0", stackout, count); end
        op(0, 1, 16'h0000, 1);
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL unf_clr_collide got=%b exp=1", underflow); end
        op(0, 0, 16'h0000, 1);
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL unf_clear got=%b exp=0", underflow); end
        // push+pop on empty behaves as a push and flags underflow.
        op(1, 1, 16'h0BEE, 0);
        total++; if (count !== 5'd1 || stackout !== 16'h0BEE || underflow !== 1'b1) begin
            bad++; $display("FAIL pushpop_empty got=%0d/%h/%b exp=1/0bee/1", count, stackout, underflow);
        end
        op(0, 1, 16'h0000, 1);
        total++; if (count !== 5'd0 || stackout !== 16'h0000 || underflow !== 1'b0) begin
            bad++; $display("FAIL pushpop_empty_pop got=%0d/%h/%b exp=0/0000/0", count, stackout, underflow);
        end
    endtask

    task automatic test_replace();
        pulse_reset();
        op(1, 0, 16'h0001, 0);
        op(1, 0, 16'h0002, 0);
        op(1, 1, 16'h00AA, 0);
        total++; if (count !== 5'd2 || stackout !== 16'h00AA) begin bad++; $display("FAIL repl got=%0d/%h exp=2/00aa", count, stackout); end
        total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL repl_flags got=%b%b exp=00", overflow, underflow); end
        op(0, 1, 16'h0000, 0);
        total++; if (stackout !== 16'h0001 || count !== 5'd1) begin bad++; $display("FAIL repl_pop got=%h/%0d exp=0001/1", stackout, count); end
        // Replace while full: no overflow, sp stays at DEPTH.
        pulse_reset();
        for (int i = 0; i < 16; i++) op(1, 0, 16'h0100 + 16'(i), 0);
        op(1, 1, 16'hBEEF, 0);
        total++; if (count !== 5'd16 || full !== 1'b1 || stackout !== 16'hBEEF || overflow !== 1'b0) begin
            bad++; $display("FAIL repl_full got=%0d/%b/%h/%b exp=16/1/beef/0", count, full, stackout, overflow);
        end
        op(0, 1, 16'h0000, 0);
        total++; if (stackout !== 16'h010E || count !== 5'd15) begin bad++; $display("FAIL repl_full_pop got=%h/%0d exp=010e/15", stackout, count); end
    endtask

    task automatic test_async_reset();
        pulse_reset();
        for (int i = 0; i < 5; i++) op(1, 0, 16'h0A00 + 16'(i), 0);
        total++; if (count !== 5'd5) begin bad++; $display("FAIL ar_pre got=%0d exp=5", count); end
        #2 reset = 1'b1;
        #1;
        total++; if (count !== 5'd0 || stackout !== 16'h0000 || empty !== 1'b1) begin
            bad++; $display("FAIL ar_async got=%0d/%h/%b exp=0/0000/1", count, stackout, empty);
        end
        #1 reset = 1'b0;
        op(1, 0, 16'h5555, 0);
        total++; if (stackout !== 16'h5555 || count !== 5'd1) begin bad++; $display("FAIL ar_push got=%h/%0d exp=5555/1", stackout, count); end
        op(1, 0, 16'h6666, 0);
        op(0, 1, 16'h0000, 0);
        total++; if (stackout !== 16'h5555 || count !== 5'd1) begin bad++; $display("FAIL ar_mem0 got=%h/%0d exp=5555/1", stackout, count); end
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        op(1, 0, 16'h0011, 0);
        op(1, 0, 16'h0022, 0);
        op(0, 1, 16'h0000, 0);
        total++; if (stackout !== 16'h0011 || count !== 5'd1) begin bad++; $display("FAIL b2b_a got=%h/%0d exp=0011/1", stackout, count); end
        op(1, 0, 16'h0033, 0);
        op(1, 0, 16'h0044, 0);
        op(0, 1, 16'h0000, 0);
        op(0, 1, 16'h0000, 0);
        total++; if (stackout !== 16'h0011 || count !== 5'd1) begin bad++; $display("FAIL b2b_b got=%h/%0d exp=0011/1", stackout, count); end
        op(0, 1, 16'h0000, 0);
        total++; if (stackout !== 16'h0000 || empty !== 1'b1) begin bad++; $display("FAIL b2b_c got=%h/%b exp=0000/1", stackout, empty); end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_fill_overflow();
        test_underflow();
        test_replace();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stack_unit.md
# stack_unit

Hardware LIFO for the 16-bit CPU, sitting directly beside the ALU. It captures the ALU result on PSH and on CLL return-address saves. It returns the top-of-stack to the ALU's `stackout` input for POP and RTN. The control state machine drives single-cycle push/pop strobes. `stackout` always presents the current top so the ALU can use it combinationally during the same cycle as the pop.

## Interface

Parameters:
- `WIDTH`, 16, data word width.
- `DEPTH`, 16, number of entries; power of two, ≥2.
- `AW`, 4, log2(DEPTH).

Ports:
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- `push`  in  1  write `din` onto the stack this edge.
- `pop`  in  1  remove the top entry this edge.
- `din`  in  WIDTH  data to push (ALU `Rout`).
- `clr_err`  in  1  clear the sticky error flags.
- `stackout`  out  WIDTH  registered top-of-stack; 0 when empty.
- `count`  out  AW+1  number of valid entries, 0..DEPTH.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == DEPTH`.
- `overflow`  out  1  sticky flag: a push was rejected.
- `underflow`  out  1  sticky flag: a pop was rejected.

## Operation

- Storage: `DEPTH` x `WIDTH` register array `mem`, plus pointer `sp` (AW+1 bits) equal to `count`.
  - Valid entries are `mem[0..sp-1]`; the top is `mem[sp-1]`.
- `stackout` is a separate register, updated every edge to the next top. It is never read combinationally from `mem`.
- Action per edge:
  - `push & !pop & !full`:
    - `mem[sp] <= din`
    - `sp <= sp+1`
    - `stackout <= din`
  - `push & !pop & full`:
    - no storage change
    - `overflow <= 1`
  - `pop & !push & !empty`:
    - `sp <= sp-1`
    - `stackout <= (sp>=2) ? mem[sp-2] : 0`
  - `pop & !push & empty`:
    - no change
    - `underflow <= 1`
    - `stackout` stays 0
  - `push & pop & !empty` (replace top, including when full):
    - `mem[sp-1] <= din`
    - `sp` unchanged
    - `stackout <= din`
    - no error
  - `push & pop & empty`:
    - performed as a plain push (`sp` becomes 1, `stackout <= din`)
    - `underflow <= 1`
  - Idle: everything holds.
- Popped value: the value removed by a pop is the `stackout` value during the cycle `pop` is high, before the edge. The ALU consumes it in that cycle.
- Flags:
  - `overflow` and `underflow` are sticky until `clr_err`.
  - If `clr_err` coincides with a new error event, the error wins and the flag stays 1.
- Width rules:
  - No arithmetic on data.
  - `sp` never leaves the range 0..DEPTH; index arithmetic wraps nowhere.

## Timing

- Reset (asynchronous, immediate):
  - `sp=0`, `stackout=0`, `overflow=0`, `underflow=0`
  - `count=0`, `empty=1`, `full=0`
  - `mem` contents are not reset and are don't-care.
- Latency:
  - Push/pop take effect at the rising edge where the strobe is sampled high.
  - `stackout`, `count`, `empty` and `full` reflect the new state immediately after that edge (1-cycle latency).
- Back-to-back operations are permitted on every cycle; there is no busy state.
- Reset asserted mid-sequence discards all contents. The first push after reset release lands in `mem[0]`.
- `empty`, `full` and `count` are decoded from the registered `sp` only. They are glitch-free relative to `clk`.

## Test plan

- Reset, then push 0x1234, 0xABCD, 0x0007 on consecutive cycles.
  - After the third push: `stackout=0x0007`, `count=3`.
  - Three pops then present 0x0007, 0xABCD, 0x1234 before each edge.
  - After the last pop: `stackout=0`, `empty=1`.
- Fill with 16 pushes of values 0..15.
  - Result: `full=1`, `stackout=15`.
- Overflow:
  - From the full state of the previous case, a 17th push of 0xFFFF leaves `stackout=15` and `count=16`, and sets `overflow=1`.
  - `clr_err` clears it.
- Pop on empty after reset:
  - Result: `underflow=1`, `stackout=0`, `count=0`.
  - Then `clr_err` and pop on the same cycle: `underflow` remains 1.
- Replace top:
  - With stack [0x0001, 0x0002], drive push+pop with `din=0x00AA`.
  - Result: `count=2`, `stackout=0x00AA`.
  - A following pop yields `stackout=0x0001`.
- Asynchronous reset mid-stream:
  - After 5 pushes, pulse `reset` between clock edges.
  - Result: `count=0`, `stackout=0` before the next edge.
  - A subsequent push of 0x5555 gives `stackout=0x5555`, `count=1`.
